// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART byte receiver and the CPU control/data register pair.
// Optional interrupt logic is enabled by defining UART_RX_FIFO_IRQ_EN.
module uart_rx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rstrb_i,
    input  logic        wstrb_i,
    input  logic        sel_cntl_i,
    input  logic        sel_dat_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        rbusy_o,
    output logic        irq_o
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;
    localparam int unsigned CntW  = DEPTH_LOG2 + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [7:0]            mem_q [Depth];
    logic [DEPTH_LOG2-1:0] rp_q, rp_d;
    logic [DEPTH_LOG2-1:0] wp_q, wp_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  overflow_q, overflow_d;

    logic empty, full, pop, push, ovf_evt;
    logic cntl_wr, flush, clr_ovf;
    logic irq_en_bit;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == DepthCnt);
        cntl_wr = wstrb_i && sel_cntl_i;
        flush   = cntl_wr && wdata_i[0];
        clr_ovf = cntl_wr && wdata_i[1];
        pop     = rstrb_i && sel_dat_i && !empty;
        // A same-cycle pop frees a slot, so a full FIFO still accepts the byte.
        push    = rx_valid_i && (!full || pop);
        ovf_evt = rx_valid_i && full && !pop;
    end

    always_comb begin
        rp_d    = rp_q;
        wp_d    = wp_q;
        count_d = count_q;
        if (flush) begin
            rp_d    = '0;
            wp_d    = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                rp_d = rp_q + DEPTH_LOG2'(1);
            end
            if (push) begin
                wp_d = wp_q + DEPTH_LOG2'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
        end
        // Set beats clear; a flushed push never counts as an overflow.
        overflow_d = (overflow_q && !clr_ovf) || (ovf_evt && !flush);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rp_q       <= '0;
            wp_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rp_q       <= rp_d;
            wp_q       <= wp_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && !flush && push) begin
            mem_q[wp_q] <= rx_data_i;
        end
    end

`ifdef UART_RX_FIFO_IRQ_EN
    logic irq_en_q;
    logic irq_q;
    logic unused_wdata;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (cntl_wr) begin
                irq_en_q <= wdata_i[2];
            end
            irq_q <= irq_en_q && ((count_d != '0) || overflow_d);
        end
    end

    assign irq_en_bit   = irq_en_q;
    assign irq_o        = irq_q;
    assign unused_wdata = ^wdata_i[31:3];
`else
    logic unused_wdata;

    assign irq_en_bit   = 1'b0;
    assign irq_o        = 1'b0;
    assign unused_wdata = ^wdata_i[31:2];
`endif

    always_comb begin
        rdata_o = '0;
        if (sel_cntl_i) begin
            rdata_o[8]     = !empty;
            rdata_o[10]    = overflow_q;
            rdata_o[11]    = full;
            rdata_o[12]    = irq_en_bit;
            rdata_o[24:16] = 9'(count_q);
        end else if (sel_dat_i && !empty) begin
            rdata_o = {24'b0, mem_q[rp_q]};
        end
    end

    assign rbusy_o = 1'b0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo (DEPTH_LOG2 = 4): queue model of contents, overflow and irq.
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rstrb = 1'b0;
    logic        wstrb = 1'b0;
    logic        sel_cntl = 1'b0;
    logic        sel_dat = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rbusy;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb[$];
    logic       m_ovf = 1'b0;
    logic       m_irq_en = 1'b0;
    logic       exp_irq = 1'b0;

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data),
        .rstrb_i    (rstrb),
        .wstrb_i    (wstrb),
        .sel_cntl_i (sel_cntl),
        .sel_dat_i  (sel_dat),
        .wdata_i    (wdata),
        .rdata_o    (rdata),
        .rbusy_o    (rbusy),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_ctrl();
        logic [31:0] w;
        w = '0;
        w[8] = (sb.size() != 0);
        w[10] = m_ovf;
        w[11] = (sb.size() == 16);
        w[12] = m_irq_en;
        w[24:16] = 9'(sb.size());
        return w;
    endfunction

    function automatic logic [31:0] exp_dat();
        return (sb.size() != 0) ? {24'b0, sb[0]} : 32'b0;
    endfunction

    // Drive one cycle's inputs just after the falling edge; outputs are stable 1 ns later.
    task automatic apply(input logic rst, input logic rxv, input logic [7:0] rxd, input logic rs,
                         input logic ws, input logic sc, input logic sd, input logic [31:0] wd);
        @(negedge clk);
        reset = rst; rx_valid = rxv; rx_data = rxd; rstrb = rs;
        wstrb = ws; sel_cntl = sc; sel_dat = sd; wdata = wd;
        #1;
    endtask

    // Advance the model for the inputs currently applied, then take the clock edge.
    task automatic commit();
        logic full, pop, cw, old_en;
        logic [7:0] tmp;
        full = (sb.size() == 16);
        pop = rstrb && sel_dat && (sb.size() != 0);
        cw = wstrb && sel_cntl;
        old_en = m_irq_en;
        if (reset) begin
            sb.delete();
            m_ovf = 1'b0;
            m_irq_en = 1'b0;
            exp_irq = 1'b0;
        end else begin
            if (cw && wdata[1]) m_ovf = 1'b0;
            if (cw && wdata[0]) begin
                sb.delete();
            end else begin
                if (rx_valid && full && !pop) m_ovf = 1'b1;
                if (pop) tmp = sb.pop_front();
                if (rx_valid && (!full || pop)) sb.push_back(rx_data);
            end
`ifdef UART_RX_FIFO_IRQ_EN
            if (cw) m_irq_en = wdata[2];
            exp_irq = old_en && ((sb.size() != 0) || m_ovf);
`else
            exp_irq = 1'b0;
`endif
        end
        @(posedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        apply(0, 1, b, 0, 0, 0, 0, 0);
        commit();
    endtask

    task automatic ctrl_write(input logic [31:0] wd);
        apply(0, 0, 0, 0, 1, 1, 0, wd);
        commit();
    endtask

    task automatic test_reset();
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        commit();
        apply(1, 1, 8'hAA, 0, 1, 1, 0, 32'h7);
        commit();
        apply(0, 0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("FAIL reset_ctrl: got %h expected %h", rdata, 32'h0);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL reset_irq: got %b expected 0", irq);
        end
        checks++;
        if (rbusy !== 1'b0) begin
            errors++; $display("FAIL rbusy: got %b expected 0", rbusy);
        end
        commit();
        apply(0, 0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("FAIL reset_dat: got %h expected 0", rdata);
        end
        commit();
    endtask

    task automatic test_basic();
        logic [31:0] e;
        push_byte(8'h41);
        push_byte(8'h42);
        push_byte(8'h43);
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 1, 0, 0, 1, 0);
            e = exp_dat();
            checks++;
            if (rdata !== e || rdata !== 32'h41 + 32'(i)) begin
                errors++; $display("FAIL basic_dat[%0d]: got %h expected %h", i, rdata, e);
            end
            commit();
        end
        apply(0, 0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (rdata[8] !== 1'b0 || rdata[24:16] !== 9'd0 || rdata !== exp_ctrl()) begin
            errors++; $display("FAIL basic_ctrl: got %h expected %h", rdata, exp_ctrl());
        end
        commit();
    endtask

    task automatic test_overflow();
        for (int i = 0; i <= 16; i++) push_byte(8'(i));
        apply(0, 0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (rdata !== 32'h0010_0D00 || rdata !== exp_ctrl()) begin
            errors++; $display("FAIL ovf_ctrl: got %h expected %h", rdata, 32'h0010_0D00);
        end
        commit();
        for (int i = 0; i < 16; i++) begin
            apply(0, 0, 0, 1, 0, 0, 1, 0);
            checks++;
            if (rdata !== 32'(i) || rdata !== exp_dat()) begin
                errors++; $display("FAIL ovf_dat[%0d]: got %h expected %h", i, rdata, 32'(i));
            end
            commit();
        end
        apply(0, 0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (rdata !== 32'h0000_0400) begin
            errors++; $display("FAIL ovf_sticky: got %h expected %h", rdata, 32'h400);
        end
        commit();
    endtask

    task automatic test_full_pushpop();
        logic [31:0] e;
        ctrl_write(32'h2);
        for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
        apply(0, 1, 8'h55, 1, 0, 0, 1, 0);
        checks++;
        if (rdata !== 32'h80) begin
            errors++; $display("FAIL full_pp_dat: got %h expected %h", rdata, 32'h80);
        end
        commit();
        apply(0, 0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (rdata !== 32'h0010_0900 || rdata !== exp_ctrl()) begin
            errors++; $display("FAIL full_pp_ctrl: got %h expected %h", rdata, 32'h0010_0900);
        end
        commit();
        for (int i = 0; i < 16; i++) begin
            apply(0, 0, 0, 1, 0, 0, 1, 0);
            e = (i < 15) ? 32'h81 + 32'(i) : 32'h55;
            checks++;
            if (rdata !== e || rdata !== exp_dat()) begin
                errors++; $display("FAIL full_pp_drain[%0d]: got %h expected %h", i, rdata, e);
            end
            commit();
        end
    endtask

    task automatic test_flush();
        push_byte(8'h10);
        push_byte(8'h11);
        apply(0, 1, 8'h12, 0, 1, 1, 0, 32'h3);
        commit();
        apply(0, 0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (rdata !== 32'h0 || rdata !== exp_ctrl()) begin
            errors++; $display("FAIL flush_ctrl: got %h expected %h", rdata, 32'h0);
        end
        commit();
        apply(0, 0, 0, 1, 0, 0, 1, 0);
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("FAIL flush_dat: got %h expected 0", rdata);
        end
        commit();
    endtask

    task automatic test_irq();
        logic e1;
`ifdef UART_RX_FIFO_IRQ_EN
        e1 = 1'b1;
`else
        e1 = 1'b0;
`endif
        ctrl_write(32'h4);
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_idle: got %b expected 0", irq);
        end
        commit();
        push_byte(8'h7E);
        apply(0, 0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (irq !== e1 || irq !== exp_irq) begin
            errors++; $display("FAIL irq_rise: got %b expected %b", irq, e1);
        end
        checks++;
        if (rdata !== exp_ctrl()) begin
            errors++; $display("FAIL irq_ctrl: got %h expected %h", rdata, exp_ctrl());
        end
        commit();
        apply(0, 0, 0, 1, 0, 0, 1, 0);
        checks++;
        if (rdata !== 32'h7E || irq !== e1) begin
            errors++; $display("FAIL irq_pop: got %h/%b expected %h/%b", rdata, irq, 32'h7E, e1);
        end
        commit();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_fall: got %b expected 0", irq);
        end
        commit();
    endtask

    task automatic test_reset_midop();
        ctrl_write(32'h4);
        for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (irq !== exp_irq) begin
            errors++; $display("FAIL midrst_pre_irq: got %b expected %b", irq, exp_irq);
        end
        commit();
        apply(1, 1, 8'h99, 1, 1, 1, 1, 32'h4);
        commit();
        apply(0, 0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (rdata !== 32'h0 || irq !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl: got %h/%b expected 0/0", rdata, irq);
        end
        commit();
        apply(0, 0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("FAIL midrst_dat: got %h expected 0", rdata);
        end
        commit();
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        apply(0, 1, 8'h33, 1, 0, 0, 1, 0);
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("FAIL empty_pp_dat: got %h expected 0", rdata);
        end
        commit();
        for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(255)));
        ctrl_write(32'h0);
        apply(0, 0, 0, 0, 1, 0, 1, 32'h1);
        commit();
        apply(0, 0, 0, 1, 0, 1, 1, 0);
        checks++;
        if (rdata !== exp_ctrl()) begin
            errors++; $display("FAIL both_sel: got %h expected %h", rdata, exp_ctrl());
        end
        commit();
        for (int i = 0; i < 6; i++) begin
            apply(0, (i == 1), 8'hE1, 1, 0, 0, 1, 0);
            e = exp_dat();
            checks++;
            if (rdata !== e) begin
                errors++; $display("FAIL b2b[%0d]: got %h expected %h", i, rdata, e);
            end
            commit();
        end
        apply(0, 0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (rdata !== exp_ctrl()) begin
            errors++; $display("FAIL b2b_ctrl: got %h expected %h", rdata, exp_ctrl());
        end
        commit();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pushpop();
        test_flush();
        test_irq();
        test_reset_midop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
